// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch front end owning the PC and a single-outstanding I-cache handshake.
// Optional performance counters are compiled in with `define FETCH_PERF_EN.
module if_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_write,
    input  logic              ext_stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ack,
    input  logic [31:0]       im_rdata,
    output logic [ADDR_W-1:0] PC_out,
    output logic [ADDR_W-1:0] PCadd4_Out,
    output logic [31:0]       IM_Instruction,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_discard_cnt,
`endif
    output logic              fetch_stall
);

    typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] tgt;
    logic [31:0]       inst_buf;
    logic              redir_pend;
    logic              br;

    // A redirect is only accepted while the back end is not stalled; targets are word aligned.
    always_comb begin
        br             = branch_taken && !ext_stall;
        tgt            = branch_target & ~ADDR_W'(3);
        im_req         = (state == FETCH);
        im_addr        = pc;
        fetch_stall    = (state != READY);
        PC_out         = pc;
        PCadd4_Out     = pc + ADDR_W'(4);
        IM_Instruction = inst_buf;
    end

    // Fetch FSM: acks that race with a redirect are dropped and the request restarts at the new PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            redir_pc   <= RESET_PC;
            inst_buf   <= '0;
            redir_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (im_ack) begin
                        if (br || redir_pend) begin
                            pc         <= br ? tgt : redir_pc;
                            redir_pend <= 1'b0;
                        end else begin
                            inst_buf <= im_rdata;
                            state    <= READY;
                        end
                    end else if (br) begin
                        redir_pend <= 1'b1;
                        redir_pc   <= tgt;
                    end
                end
                READY: begin
                    if (!ext_stall && (branch_taken || pc_write)) begin
                        pc    <= branch_taken ? tgt : pc + ADDR_W'(4);
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Count cycles spent waiting on the cache and acks thrown away by redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt   <= '0;
            perf_discard_cnt <= '0;
        end else begin
            if (state == FETCH) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (state == FETCH && im_ack && (br || redir_pend)) perf_discard_cnt <= perf_discard_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scenarios plus a randomized run against a transaction-level fetch model.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b0;
    logic        ext_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack = 1'b0;
    logic [31:0] im_rdata = '0;
    logic [31:0] PC_out;
    logic [31:0] PCadd4_Out;
    logic [31:0] IM_Instruction;
    logic        fetch_stall;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_discard_cnt;
`endif

    int total = 0;
    int bad = 0;

    if_fetch_ctrl dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .ext_stall(ext_stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
        .PC_out(PC_out), .PCadd4_Out(PCadd4_Out), .IM_Instruction(IM_Instruction),
`ifdef FETCH_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_discard_cnt(perf_discard_cnt),
`endif
        .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_1234;
    endfunction

    task automatic do_reset;
        rst = 1'b1; pc_write = 0; ext_stall = 0; branch_taken = 0; im_ack = 0; im_rdata = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic boot(input logic [31:0] d);
        do_reset;
        @(negedge clk);
        im_ack = 1; im_rdata = d;
        @(negedge clk);
        im_ack = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        total++; if (im_req !== 1'b0) begin bad++; $display("FAIL reset_im_req got=%b want=0", im_req); end
        total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b want=1", fetch_stall); end
        total++; if (IM_Instruction !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h want=0", IM_Instruction); end
        total++; if (PC_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", PC_out); end
        total++; if (PCadd4_Out !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h want=4", PCadd4_Out); end
`ifdef FETCH_PERF_EN
        total++; if (perf_stall_cnt !== 32'h0 || perf_discard_cnt !== 32'h0) begin bad++; $display("FAIL reset_perf got=%0d/%0d want=0/0", perf_stall_cnt, perf_discard_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_hit;
        @(negedge clk);
        total++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin bad++; $display("FAIL hit_req got=%b/%h want=1/0", im_req, im_addr); end
        im_ack = 1; im_rdata = 32'h13;
        @(negedge clk);
        im_ack = 0;
        total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL hit_ready got=%b want=0", fetch_stall); end
        total++; if (IM_Instruction !== 32'h13) begin bad++; $display("FAIL hit_inst got=%h want=13", IM_Instruction); end
        total++; if (PC_out !== 32'h0 || PCadd4_Out !== 32'h4) begin bad++; $display("FAIL hit_pc got=%h/%h want=0/4", PC_out, PCadd4_Out); end
    endtask

    task automatic test_sequential;
        for (int k = 1; k <= 2; k++) begin
            pc_write = 1;
            @(negedge clk);
            pc_write = 0;
            total++; if (fetch_stall !== 1'b1 || im_addr !== 32'(4 * k)) begin bad++; $display("FAIL seq_fetch got=%b/%h want=1/%h", fetch_stall, im_addr, 32'(4 * k)); end
            im_ack = 1; im_rdata = 32'(k);
            @(negedge clk);
            im_ack = 0;
            total++; if (fetch_stall !== 1'b0 || PC_out !== 32'(4 * k) || IM_Instruction !== 32'(k)) begin bad++; $display("FAIL seq_ready got=%b/%h/%h want=0/%h/%h", fetch_stall, PC_out, IM_Instruction, 32'(4 * k), 32'(k)); end
        end
    endtask

    task automatic test_miss_hold;
        pc_write = 1;
        @(negedge clk);
        pc_write = 0;
        for (int i = 0; i < 10; i++) begin
            total++; if (im_req !== 1'b1 || im_addr !== 32'hC || fetch_stall !== 1'b1) begin bad++; $display("FAIL miss_wait cyc=%0d got=%b/%h/%b want=1/c/1", i, im_req, im_addr, fetch_stall); end
            @(negedge clk);
        end
        im_ack = 1; im_rdata = 32'hAA;
        @(negedge clk);
        im_ack = 0; ext_stall = 1; pc_write = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (fetch_stall !== 1'b0 || PC_out !== 32'hC || IM_Instruction !== 32'hAA) begin bad++; $display("FAIL ext_hold cyc=%0d got=%b/%h/%h want=0/c/aa", i, fetch_stall, PC_out, IM_Instruction); end
        end
        ext_stall = 0; pc_write = 0;
    endtask

    task automatic test_redirect_miss;
        boot(32'h13);
        pc_write = 1;
        @(negedge clk);
        pc_write = 0;
        @(negedge clk);
        @(negedge clk);
        branch_taken = 1; branch_target = 32'h102;
        @(negedge clk);
        branch_taken = 0;
        total++; if (im_addr !== 32'h4) begin bad++; $display("FAIL redir_hold_addr got=%h want=4", im_addr); end
        @(negedge clk);
        @(negedge clk);
        im_ack = 1; im_rdata = 32'hDEAD;
        @(negedge clk);
        total++; if (fetch_stall !== 1'b1 || im_req !== 1'b1 || im_addr !== 32'h100) begin bad++; $display("FAIL redir_refetch got=%b/%b/%h want=1/1/100", fetch_stall, im_req, im_addr); end
        im_rdata = 32'h55;
        @(negedge clk);
        im_ack = 0;
        total++; if (fetch_stall !== 1'b0 || PC_out !== 32'h100 || IM_Instruction !== 32'h55) begin bad++; $display("FAIL redir_ready got=%b/%h/%h want=0/100/55", fetch_stall, PC_out, IM_Instruction); end
`ifdef FETCH_PERF_EN
        total++; if (perf_discard_cnt !== 32'd1) begin bad++; $display("FAIL redir_discard got=%0d want=1", perf_discard_cnt); end
        total++; if (perf_stall_cnt !== 32'd8) begin bad++; $display("FAIL redir_stallcnt got=%0d want=8", perf_stall_cnt); end
`endif
    endtask

    task automatic test_hazard;
        boot(32'h13);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (fetch_stall !== 1'b0 || PC_out !== 32'h0) begin bad++; $display("FAIL hazard_hold got=%b/%h want=0/0", fetch_stall, PC_out); end
        end
        branch_taken = 1; branch_target = 32'h2007;
        @(negedge clk);
        branch_taken = 0;
        total++; if (im_req !== 1'b1 || im_addr !== 32'h2004) begin bad++; $display("FAIL hazard_branch got=%b/%h want=1/2004", im_req, im_addr); end
        im_ack = 1; im_rdata = 32'h77;
        @(negedge clk);
        im_ack = 0;
        total++; if (PC_out !== 32'h2004 || IM_Instruction !== 32'h77) begin bad++; $display("FAIL hazard_ready got=%h/%h want=2004/77", PC_out, IM_Instruction); end
        branch_taken = 1; branch_target = 32'hFFFF_FFFF;
        @(negedge clk);
        branch_taken = 0;
        total++; if (im_addr !== 32'hFFFF_FFFC || PCadd4_Out !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h/%h want=fffffffc/0", im_addr, PCadd4_Out); end
        im_ack = 1; im_rdata = 32'h1;
        @(negedge clk);
        im_ack = 0; pc_write = 1;
        @(negedge clk);
        pc_write = 0;
        total++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%b/%h want=1/0", im_req, im_addr); end
    endtask

    task automatic test_async_reset;
        boot(32'h13);
        pc_write = 1;
        @(negedge clk);
        pc_write = 0;
        total++; if (im_req !== 1'b1 || PC_out !== 32'h4) begin bad++; $display("FAIL areset_pre got=%b/%h want=1/4", im_req, PC_out); end
        #2 rst = 1;
        #1;
        total++; if (im_req !== 1'b0 || PC_out !== 32'h0 || fetch_stall !== 1'b1) begin bad++; $display("FAIL areset_now got=%b/%h/%b want=0/0/1", im_req, PC_out, fetch_stall); end
        @(negedge clk);
        rst = 0; im_ack = 1; im_rdata = 32'h99;
        @(negedge clk);
        total++; if (fetch_stall !== 1'b1 || im_req !== 1'b1) begin bad++; $display("FAIL idle_ack got=%b/%b want=1/1", fetch_stall, im_req); end
        im_rdata = 32'h31;
        @(negedge clk);
        im_ack = 0;
        total++; if (fetch_stall !== 1'b0 || IM_Instruction !== 32'h31 || PC_out !== 32'h0) begin bad++; $display("FAIL idle_after got=%b/%h/%h want=0/31/0", fetch_stall, IM_Instruction, PC_out); end
    endtask

    task automatic test_random;
        logic [31:0] exp_pc = 32'h0, prev_addr = '0, t;
        logic        pend = 0, prev_req = 0, prev_ack = 0, req, ready, br;
        int          cnt = -1;
        int          exp_disc = 0, exp_stall = 0;
        do_reset;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            req = im_req; ready = !fetch_stall;
            if (ready) begin
                total++; if (PC_out !== exp_pc || PCadd4_Out !== exp_pc + 32'd4 || IM_Instruction !== mem(exp_pc) || im_req !== 1'b0) begin bad++; $display("FAIL rnd_ready n=%0d got=%h/%h/%h want=%h/%h/%h", n, PC_out, PCadd4_Out, IM_Instruction, exp_pc, exp_pc + 32'd4, mem(exp_pc)); end
            end
            if (req && prev_req && !prev_ack) begin
                total++; if (im_addr !== prev_addr) begin bad++; $display("FAIL rnd_stable n=%0d got=%h want=%h", n, im_addr, prev_addr); end
            end
            im_ack = 0; im_rdata = $urandom;
            if (req) begin
                if (cnt < 0) cnt = $urandom_range(0, 3);
                if (cnt == 0) begin im_ack = 1; im_rdata = mem(im_addr); cnt = -1; end
                else cnt--;
            end
            ext_stall = ($urandom % 4) == 0;
            branch_taken = ($urandom % 6) == 0;
            t = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
            branch_target = t;
            pc_write = ($urandom % 3) != 0;
            br = branch_taken && !ext_stall;
            if (req) exp_stall++;
            if (ready) begin
                if (br) exp_pc = t & ~32'h3;
                else if (pc_write && !ext_stall) exp_pc = exp_pc + 32'd4;
            end else if (req) begin
                if (im_ack) begin
                    if (br || pend) begin
                        exp_disc++;
                        if (br) exp_pc = t & ~32'h3;
                    end else begin
                        total++; if (im_addr !== exp_pc) begin bad++; $display("FAIL rnd_addr n=%0d got=%h want=%h", n, im_addr, exp_pc); end
                    end
                    pend = 0;
                end else if (br) begin
                    exp_pc = t & ~32'h3;
                    pend = 1;
                end
            end
            prev_req = req; prev_ack = im_ack; prev_addr = im_addr;
        end
        @(negedge clk);
        im_ack = 0; branch_taken = 0; pc_write = 0;
`ifdef FETCH_PERF_EN
        total++; if (perf_discard_cnt !== 32'(exp_disc)) begin bad++; $display("FAIL rnd_discard got=%0d want=%0d", perf_discard_cnt, exp_disc); end
        total++; if (perf_stall_cnt !== 32'(exp_stall)) begin bad++; $display("FAIL rnd_stallcnt got=%0d want=%0d", perf_stall_cnt, exp_stall); end
`else
        total++; if (exp_disc == 0) begin bad++; $display("FAIL rnd_coverage got=0 discards want>0"); end
`endif
    endtask

    initial begin
        test_reset;
        test_hit;
        test_sequential;
        test_miss_hold;
        test_redirect_miss;
        test_hazard;
        test_async_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
